// File: rtl/aes_nibble_seq.sv
// aes_nibble_seq: nibble-serial wrapper around a 128-bit AES core (load, kick, wait, unload)
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a transaction (sampled only while idle)
//   block_nib, key_nib      plaintext / key nibbles, MSB nibble first, one per LOAD cycle
//   text_in, key_in, ld     assembled operands and one-cycle start strobe to the core
//   core_done, core_text_out core result pulse and ciphertext
//   dout, dout_valid, dout_ready ciphertext nibble stream, MSB nibble first
//   busy, err               not idle / sticky wait timeout
module aes_nibble_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   block_nib,
    input  logic [3:0]   key_nib,
    output logic [127:0] text_in,
    output logic [127:0] key_in,
    output logic         ld,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic [3:0]   dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, UNLOAD} state_t;
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
    state_t state;
    logic [127:0] text_r, key_r, out_r;
    logic [4:0] cnt;
    logic [7:0] timer;
    assign text_in = text_r;
    assign key_in = key_r;
    assign dout = out_r[127:124];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            text_r <= '0;
            key_r <= '0;
            out_r <= '0;
            cnt <= '0;
            timer <= '0;
            ld <= 1'b0;
            dout_valid <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ld <= 1'b0;
                    dout_valid <= 1'b0;
                    busy <= start;
                    if (start) begin
                        state <= LOAD;
                        cnt <= '0;
                        err <= 1'b0;
                    end
                end
                LOAD: begin
                    text_r <= {text_r[123:0], block_nib};
                    key_r <= {key_r[123:0], key_nib};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= KICK;
                        ld <= 1'b1;
                    end
                end
                KICK: begin
                    ld <= 1'b0;
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // a result arriving on the timeout cycle still wins
                    if (core_done) begin
                        out_r <= core_text_out;
                        cnt <= '0;
                        dout_valid <= 1'b1;
                        state <= UNLOAD;
                    end else begin
                        timer <= timer + 8'd1;
                        if (timer == TMAX) begin
                            err <= 1'b1;
                            busy <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                UNLOAD: begin
                    if (dout_valid && dout_ready) begin
                        out_r <= {out_r[123:0], 4'h0};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            dout_valid <= 1'b0;
                            busy <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ld <= 1'b0;
                    dout_valid <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_nibble_seq.sv
// tb_aes_nibble_seq: checks two instances (TIMEOUT 64 and 8) sharing stimulus against a behavioural model
module tb_aes_nibble_seq;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int TO [2] = '{64, 8};
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, core_done = 1'b0, dout_ready = 1'b1;
    logic [3:0] block_nib = '0, key_nib = '0;
    logic [127:0] core_text_out = '0;
    logic [127:0] text_w [2], key_w [2];
    logic ld_w [2], dv_w [2], busy_w [2], err_w [2];
    logic [3:0] dout_w [2];
    int checks = 0, fails = 0;
    bit core_en = 1'b1;
    int core_lat = 10, core_cnt = 0, ld_cnt = 0;
    logic [127:0] ct_next = CT;
    logic [3:0] got_q [$];
    int ph_m [2], nload_m [2], nwait_m [2], idx_m [2];
    logic [127:0] tx_m [2], ky_m [2], ct_m [2];
    bit err_m [2];

    always #5 clk = ~clk;

    aes_nibble_seq dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .block_nib(block_nib), .key_nib(key_nib),
        .text_in(text_w[0]), .key_in(key_w[0]), .ld(ld_w[0]), .core_done(core_done),
        .core_text_out(core_text_out), .dout(dout_w[0]), .dout_valid(dv_w[0]),
        .dout_ready(dout_ready), .busy(busy_w[0]), .err(err_w[0])
    );
    aes_nibble_seq #(.TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .block_nib(block_nib), .key_nib(key_nib),
        .text_in(text_w[1]), .key_in(key_w[1]), .ld(ld_w[1]), .core_done(core_done),
        .core_text_out(core_text_out), .dout(dout_w[1]), .dout_valid(dv_w[1]),
        .dout_ready(dout_ready), .busy(busy_w[1]), .err(err_w[1])
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // phases: 0 idle, 1 loading, 2 kick, 3 waiting for core, 4 unloading
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                ph_m[k] = 0; tx_m[k] = '0; ky_m[k] = '0; ct_m[k] = '0; idx_m[k] = 0; err_m[k] = 0;
            end else begin
                case (ph_m[k])
                    0: if (start) begin ph_m[k] = 1; nload_m[k] = 0; err_m[k] = 0; end
                    1: begin
                        tx_m[k] = (tx_m[k] << 4) | 128'(block_nib);
                        ky_m[k] = (ky_m[k] << 4) | 128'(key_nib);
                        nload_m[k]++;
                        if (nload_m[k] == 32) ph_m[k] = 2;
                    end
                    2: begin ph_m[k] = 3; nwait_m[k] = 0; end
                    3: if (core_done) begin
                        ct_m[k] = core_text_out; idx_m[k] = 0; ph_m[k] = 4;
                    end else begin
                        nwait_m[k]++;
                        if (nwait_m[k] == TO[k]) begin err_m[k] = 1; ph_m[k] = 0; end
                    end
                    default: if (dout_ready) begin
                        idx_m[k]++;
                        if (idx_m[k] == 32) ph_m[k] = 0;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ld%0d", k), ld_w[k], ph_m[k] == 2);
            chk($sformatf("busy%0d", k), busy_w[k], ph_m[k] != 0);
            chk($sformatf("dout_valid%0d", k), dv_w[k], ph_m[k] == 4);
            chk($sformatf("dout%0d", k), dout_w[k], ph_m[k] == 4 ? ct_m[k][(31 - idx_m[k]) * 4 +: 4] : 4'h0);
            chk($sformatf("err%0d", k), err_w[k], err_m[k]);
            chk($sformatf("text_in%0d", k), text_w[k], tx_m[k]);
            chk($sformatf("key_in%0d", k), key_w[k], ky_m[k]);
        end
        if (dv_w[0] && dout_ready) got_q.push_back(dout_w[0]);
        if (ld_w[0]) ld_cnt++;
    end

    // advance one cycle; the core answers core_lat cycles after it sees ld
    task automatic tick();
        @(posedge clk);
        #1;
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) core_done = 1'b1;
        end
        core_text_out = core_done ? ct_next : {$urandom, $urandom, $urandom, $urandom};
        if (ld_w[0] && core_en) core_cnt = core_lat;
    endtask

    task automatic load(input logic [127:0] pt, input logic [127:0] ky, input bit hold, input int pulse_at);
        start = 1'b1;
        tick();
        start = hold;
        for (int i = 0; i < 32; i++) begin
            block_nib = pt[(31 - i) * 4 +: 4];
            key_nib = ky[(31 - i) * 4 +: 4];
            if (i == pulse_at) core_done = 1'b1;
            if (i == 31) chk("ld_before_kick", ld_w[0], 0);
            tick();
        end
        chk("ld_at_kick", ld_w[0], 1);
        chk("text_at_kick", text_w[0], pt);
        chk("key_at_kick", key_w[0], ky);
    endtask

    task automatic wait_idle(input int maxc, input bit bp);
        int n = 0;
        while ((busy_w[0] || busy_w[1]) && n < maxc) begin
            if (bp) dout_ready = ~dout_ready;
            tick();
            n++;
        end
        dout_ready = 1'b1;
        chk("wait_idle_timeout", n < maxc, 1);
    endtask

    function automatic logic [127:0] pack();
        logic [127:0] v = '0;
        foreach (got_q[i]) v = {v[123:0], got_q[i]};
        return v;
    endfunction

    task automatic reset_now(input string nm);
        rst_n = 1'b0;
        core_cnt = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_busy"}, busy_w[k], 0);
            chk({nm, "_ld"}, ld_w[k], 0);
            chk({nm, "_dv"}, dv_w[k], 0);
            chk({nm, "_dout"}, dout_w[k], 0);
            chk({nm, "_err"}, err_w[k], 0);
            chk({nm, "_text"}, text_w[k], 0);
            chk({nm, "_key"}, key_w[k], 0);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic rnd_txn(input string nm, input bit bp);
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] ky = {$urandom, $urandom, $urandom, $urandom};
        ct_next = {$urandom, $urandom, $urandom, $urandom};
        core_lat = $urandom_range(1, 7);
        got_q.delete();
        load(pt, ky, 0, -1);
        wait_idle(300, bp);
        chk({nm, "_count"}, got_q.size(), 32);
        chk({nm, "_cipher"}, pack(), ct_next);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        chk("reset_busy", busy_w[0], 0);
        chk("reset_dout_valid", dv_w[0], 0);
        rst_n = 1'b1;
        tick();
        // known-answer transaction; the TIMEOUT=8 instance expires before the result arrives
        got_q.delete();
        load(PT, KEY, 0, -1);
        tick();
        chk("ld_one_cycle", ld_w[0], 0);
        wait_idle(200, 0);
        chk("kat_count", got_q.size(), 32);
        chk("kat_first_nibble", got_q.size() > 0 ? got_q[0] : 4'hx, 4'h6);
        chk("kat_cipher", pack(), CT);
        chk("kat_err_a", err_w[0], 0);
        chk("kat_err_b", err_w[1], 1);
        // backpressure, ready toggling every cycle
        rnd_txn("bp", 1);
        chk("bp_err_b_cleared", err_w[1], 0);
        // timeout with the core silent
        core_en = 1'b0;
        load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, -1);
        repeat (8) tick();
        chk("to_busy_before", busy_w[1], 1);
        chk("to_err_before", err_w[1], 0);
        tick();
        chk("to_busy_after", busy_w[1], 0);
        chk("to_err_after", err_w[1], 1);
        wait_idle(200, 0);
        chk("to_err_a", err_w[0], 1);
        // result arrives on the very cycle the short timeout would fire
        core_en = 1'b1;
        core_lat = 8;
        ct_next = {$urandom, $urandom, $urandom, $urandom};
        got_q.delete();
        load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, -1);
        chk("tie_err_cleared_a", err_w[0], 0);
        chk("tie_err_cleared_b", err_w[1], 0);
        repeat (8) tick();
        chk("tie_not_yet_unload", dv_w[1], 0);
        tick();
        chk("tie_unload_b", dv_w[1], 1);
        chk("tie_err_b", err_w[1], 0);
        wait_idle(200, 0);
        chk("tie_cipher", pack(), ct_next);
        // reset at load count 17
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            block_nib = 4'($urandom);
            key_nib = 4'($urandom);
            tick();
        end
        reset_now("rst_load");
        rnd_txn("post_rst_load", 0);
        // reset while unloading nibble 5
        ct_next = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 3;
        got_q.delete();
        load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, -1);
        n = 0;
        while (got_q.size() < 5 && n < 100) begin tick(); n++; end
        chk("rst_unload_reached", n < 100, 1);
        reset_now("rst_unload");
        rnd_txn("post_rst_unload", 1);
        // start held high with a stray core_done during LOAD
        core_lat = 5;
        ct_next = {$urandom, $urandom, $urandom, $urandom};
        got_q.delete();
        ld_cnt = 0;
        load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 10);
        n = 0;
        while (busy_w[0] && n < 200) begin tick(); n++; end
        chk("hold_reached_idle", n < 200, 1);
        chk("hold_single_ld", ld_cnt, 1);
        chk("hold_cipher", pack(), ct_next);
        tick();
        chk("hold_restart", busy_w[0], 1);
        start = 1'b0;
        wait_idle(300, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
